con_ff_gen: RTL and testbench

CON_FF_GEN -- requirements
Module: con_ff_gen

---
 rtl/con_ff_gen.sv | 101 ++++++++++
 tb/tb_con_ff_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/con_ff_gen.sv
// Conditional branch flip-flop: evaluates a condition code against a bus value and holds the decision until acknowledged.
// Optional statistics counters are enabled by defining CON_FF_GEN_STATS_EN.
module con_ff_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             con_in,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] bus_mux_out,
    input  logic             con_ack,
    output logic             con_out,
    output logic             con_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t state;
    logic   is_zero;
    logic   is_neg;
    logic   cond_true;

    assign is_zero = (bus_mux_out == '0);
    assign is_neg  = bus_mux_out[WIDTH-1];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = is_zero;
            3'b001:  cond_true = !is_zero;
            3'b010:  cond_true = !is_neg;
            3'b011:  cond_true = is_neg;
            3'b100:  cond_true = !is_neg && !is_zero;
            3'b101:  cond_true = is_neg || is_zero;
            3'b110:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // A capture while VALID counts as an overrun unless the same cycle also acknowledges.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            con_out <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (con_in) begin
                        con_out <= cond_true;
                        state   <= VALID;
                    end
                end
                VALID: begin
                    if (con_in) begin
                        con_out <= cond_true;
                        if (!con_ack)
                            overrun <= 1'b1;
                    end else if (con_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign con_valid = (state == VALID);

`ifdef CON_FF_GEN_STATS_EN
    logic [CNT_W-1:0] eval_q;
    logic [CNT_W-1:0] taken_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            eval_q  <= '0;
            taken_q <= '0;
        end else if (con_in) begin
            if (eval_q != '1)
                eval_q <= eval_q + CNT_W'(1);
            if (cond_true && (taken_q != '1))
                taken_q <= taken_q + CNT_W'(1);
        end
    end

    assign eval_cnt  = eval_q;
    assign taken_cnt = taken_q;
`else
    assign eval_cnt  = '0;
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_con_ff_gen.sv
// Randomized self-checking bench for con_ff_gen; a 32-bit and an 8-bit instance share control inputs.
module tb_con_ff_gen;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        con_in;
    logic [2:0]  cond;
    logic [31:0] bus32;
    logic [7:0]  bus8;
    logic        con_ack;

    logic        out32, valid32, ovr32;
    logic [15:0] eval32, taken32;
    logic        out8, valid8, ovr8;
    logic [3:0]  eval8, taken8;

    int checks   = 0;
    int failures = 0;

    logic expValid, expOverrun, expOut32, expOut8;
    int   evalCount, taken32Count, taken8Count;

    con_ff_gen #(.WIDTH(32), .CNT_W(16)) dut32 (
        .clk(clk), .clear_n(clear_n), .con_in(con_in), .cond(cond),
        .bus_mux_out(bus32), .con_ack(con_ack), .con_out(out32),
        .con_valid(valid32), .overrun(ovr32), .eval_cnt(eval32), .taken_cnt(taken32)
    );

    con_ff_gen #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .clear_n(clear_n), .con_in(con_in), .cond(cond),
        .bus_mux_out(bus8), .con_ack(con_ack), .con_out(out8),
        .con_valid(valid8), .overrun(ovr8), .eval_cnt(eval8), .taken_cnt(taken8)
    );

    always #5 clk = ~clk;

    // Condition meaning expressed on the signed integer value of the bus.
    function automatic logic refCond(input logic [2:0] c, input longint v);
        case (c)
            3'd0: return v == 0;
            3'd1: return v != 0;
            3'd2: return v >= 0;
            3'd3: return v < 0;
            3'd4: return v > 0;
            3'd5: return v <= 0;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic longint satCount(input int n, input int cntW);
        longint maxVal;
        maxVal = (longint'(1) << cntW) - 1;
        return (n > maxVal) ? maxVal : longint'(n);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        expValid     = 1'b0;
        expOverrun   = 1'b0;
        expOut32     = 1'b0;
        expOut8      = 1'b0;
        evalCount    = 0;
        taken32Count = 0;
        taken8Count  = 0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".con_out32"}, 64'(out32), 64'(expOut32));
        checkOutput({tag, ".con_out8"}, 64'(out8), 64'(expOut8));
        checkOutput({tag, ".con_valid32"}, 64'(valid32), 64'(expValid));
        checkOutput({tag, ".con_valid8"}, 64'(valid8), 64'(expValid));
        checkOutput({tag, ".overrun32"}, 64'(ovr32), 64'(expOverrun));
        checkOutput({tag, ".overrun8"}, 64'(ovr8), 64'(expOverrun));
`ifdef CON_FF_GEN_STATS_EN
        checkOutput({tag, ".eval32"}, 64'(eval32), 64'(satCount(evalCount, 16)));
        checkOutput({tag, ".taken32"}, 64'(taken32), 64'(satCount(taken32Count, 16)));
        checkOutput({tag, ".eval8"}, 64'(eval8), 64'(satCount(evalCount, 4)));
        checkOutput({tag, ".taken8"}, 64'(taken8), 64'(satCount(taken8Count, 4)));
`else
        checkOutput({tag, ".eval32"}, 64'(eval32), 64'd0);
        checkOutput({tag, ".taken32"}, 64'(taken32), 64'd0);
        checkOutput({tag, ".eval8"}, 64'(eval8), 64'd0);
        checkOutput({tag, ".taken8"}, 64'(taken8), 64'd0);
`endif
    endtask

    // Drives one cycle of inputs (caller is mid-cycle), advances the model at the edge, checks 1 time unit later.
    task automatic applyStimulus(input string tag, input logic ci, input logic [2:0] c,
                                 input logic [31:0] b32, input logic [7:0] b8, input logic ack);
        logic r32, r8;
        con_in  = ci;
        cond    = c;
        bus32   = b32;
        bus8    = b8;
        con_ack = ack;
        r32 = refCond(c, longint'($signed(b32)));
        r8  = refCond(c, longint'($signed(b8)));
        @(posedge clk);
        if (ci) begin
            if (expValid && !ack)
                expOverrun = 1'b1;
            expValid = 1'b1;
            expOut32 = r32;
            expOut8  = r8;
            evalCount++;
            if (r32) taken32Count++;
            if (r8)  taken8Count++;
        end else if (ack) begin
            expValid = 1'b0;
        end
        #1;
        con_in  = 1'b0;
        con_ack = 1'b0;
        checkAll(tag);
    endtask

    task automatic midCycleReset(input string tag);
        #2;
        clear_n = 1'b0;
        #1;
        resetModel();
        checkAll(tag);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rb32;
        logic [7:0]  rb8;
        clear_n = 1'b0;
        con_in  = 1'b0;
        cond    = 3'd0;
        bus32   = '0;
        bus8    = '0;
        con_ack = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        clear_n = 1'b1;

        applyStimulus("zero_cap", 1, 3'b000, 32'h0, 8'h00, 0);
        applyStimulus("ack", 0, 3'b000, 32'h0, 8'h00, 1);
        applyStimulus("idle_ack", 0, 3'b111, 32'h1234, 8'h12, 1);
        applyStimulus("gt0_zero", 1, 3'b100, 32'h0, 8'h00, 0);
        applyStimulus("gt0_one", 1, 3'b100, 32'h1, 8'h01, 1);
        applyStimulus("le0_min", 1, 3'b101, 32'h8000_0000, 8'h80, 1);
        applyStimulus("ack2", 0, 3'b000, 32'h0, 8'h00, 1);
        applyStimulus("lt0_ones", 1, 3'b011, 32'hFFFF_FFFF, 8'hFF, 0);
        applyStimulus("overrun", 1, 3'b010, 32'h5, 8'h05, 0);
        applyStimulus("ack_sticky", 0, 3'b000, 32'h0, 8'h00, 1);
        applyStimulus("w8_neg", 1, 3'b011, 32'h0000_0080, 8'h80, 0);
        applyStimulus("w8_nz", 1, 3'b001, 32'h0000_0100, 8'h00, 1);

        midCycleReset("reset_mid1");
        applyStimulus("cap", 1, 3'b110, 32'h0, 8'h00, 0);
        applyStimulus("ack_cap_never", 1, 3'b111, 32'h7, 8'h07, 1);

        for (int i = 0; i < 20; i++)
            applyStimulus("always", 1, 3'b110, $urandom, 8'($urandom), 1);
        midCycleReset("reset_mid2");

        // First edge after release must capture normally.
        clear_n = 1'b1;
        applyStimulus("post_release", 1, 3'b001, 32'h10, 8'h10, 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: begin rb32 = '0;           rb8 = '0;    end
                1: begin rb32 = 32'h8000_0000; rb8 = 8'h80; end
                2: begin rb32 = '1;           rb8 = '1;    end
                default: begin rb32 = $urandom; rb8 = 8'($urandom); end
            endcase
            applyStimulus("rand", 1'($urandom_range(0, 1)), 3'($urandom), rb32, rb8,
                          1'($urandom_range(0, 1)));
            if (i == 150)
                midCycleReset("reset_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
